// File: rtl/signext_pipe.sv
// Immediate extender (sign/zero/branch/upper) behind a valid/ready output buffer.
// Define SIGNEXT_PIPE_SKID_EN for the two-entry skid buffer with registered in_ready.
module signext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
);

    if (OUT_W < IN_W + 2) begin : g_bad_width
        $error("signext_pipe: OUT_W must be >= IN_W+2");
    end

    function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm,
                                                input logic [1:0] mode);
        logic [OUT_W-1:0] sx;
        sx = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
        case (mode)
            2'b00:   extend = sx;
            2'b01:   extend = {{(OUT_W-IN_W){1'b0}}, imm};
            2'b10:   extend = sx << 2;
            default: extend = {imm, {(OUT_W-IN_W){1'b0}}};
        endcase
    endfunction

    logic [OUT_W-1:0] res;
    logic             acc, dlv;
    logic [OUT_W-1:0] head_q;
    logic             vld_q;

    assign res       = extend(in_imm, in_mode);
    assign out_valid = vld_q;
    assign out_data  = head_q;
    assign acc       = in_valid && in_ready;
    assign dlv       = vld_q && out_ready;

`ifdef SIGNEXT_PIPE_SKID_EN
    typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_state_t;

    buf_state_t       state_q;
    logic [OUT_W-1:0] tail_q;
    logic             rdy_q;

    assign in_ready = rdy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    rdy_q <= 1'b1;
                    if (acc) begin
                        head_q  <= res;
                        vld_q   <= 1'b1;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (acc && !dlv) begin
                        tail_q  <= res;
                        rdy_q   <= 1'b0;
                        state_q <= FULL;
                    end else if (!acc && dlv) begin
                        vld_q   <= 1'b0;
                        state_q <= EMPTY;
                    end else if (acc) begin
                        head_q  <= res;
                    end
                end
                FULL: begin
                    // acc cannot occur here: rdy_q is low throughout FULL
                    if (dlv) begin
                        head_q  <= tail_q;
                        rdy_q   <= 1'b1;
                        state_q <= ONE;
                    end
                end
                default: begin
                    vld_q   <= 1'b0;
                    rdy_q   <= 1'b1;
                    state_q <= EMPTY;
                end
            endcase
        end
    end
`else
    logic live_q;

    // live_q keeps in_ready low while reset is held and until the first edge after release
    assign in_ready = live_q && (!vld_q || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q <= 1'b0;
            vld_q  <= 1'b0;
            head_q <= '0;
        end else begin
            live_q <= 1'b1;
            if (acc) begin
                head_q <= res;
                vld_q  <= 1'b1;
            end else if (dlv) begin
                vld_q  <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_signext_pipe.sv
// Directed bench for signext_pipe (IN_W=16, OUT_W=32): vectors, backpressure, stream, reset.
module tb_signext_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_imm = '0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;

    int errors = 0;
    int checks = 0;

    signext_pipe #(.IN_W(16), .OUT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [15:0] imm, input logic [1:0] mode);
        case (mode)
            2'b00:   model = {{16{imm[15]}}, imm};
            2'b01:   model = {16'h0000, imm};
            2'b10:   model = {{14{imm[15]}}, imm, 2'b00};
            default: model = {imm, 16'h0000};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // one item through an idle block with out_ready=1; input scrambled after accept
    task automatic send_one(input string tag, input logic [1:0] mode, input logic [15:0] imm,
                            input logic [31:0] exp);
        in_valid = 1'b1; in_mode = mode; in_imm = imm;
        @(negedge clk);
        in_valid = 1'b0; in_imm = ~imm; in_mode = ~mode;
        chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        chk(tag, out_data, exp);
        @(negedge clk);
        chk({tag, "_gone"}, {31'd0, out_valid}, 32'd0);
    endtask

    logic [31:0] q[$];
    int          sent, got, cyc;
    logic [15:0] r_imm;
    logic [1:0]  r_mode;

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // directed extension vectors
        send_one("sx_8000", 2'b00, 16'h8000, 32'hFFFF8000);
        send_one("sx_7fff", 2'b00, 16'h7FFF, 32'h00007FFF);
        send_one("zx_8000", 2'b01, 16'h8000, 32'h00008000);
        send_one("up_1234", 2'b11, 16'h1234, 32'h12340000);
        send_one("br_ffff", 2'b10, 16'hFFFF, 32'hFFFFFFFC);
        send_one("br_0001", 2'b10, 16'h0001, 32'h00000004);
        send_one("br_8000", 2'b10, 16'h8000, 32'hFFFE0000);

        // backpressure
        out_ready = 1'b0;
`ifdef SIGNEXT_PIPE_SKID_EN
        in_valid = 1'b1; in_mode = 2'b00; in_imm = 16'hAAAA;   // A
        @(negedge clk);
        chk("bp_rdy_after_a", {31'd0, in_ready}, 32'd1);
        in_mode = 2'b01; in_imm = 16'hBBBB;                      // B
        @(negedge clk);
        chk("bp_rdy_after_b", {31'd0, in_ready}, 32'd0);
        in_mode = 2'b11; in_imm = 16'hCCCC;                      // C held
        repeat (2) @(negedge clk);
        chk("bp_hold_a", out_data, 32'hFFFFAAAA);
        chk("bp_rdy_full", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_b", out_data, 32'h0000BBBB);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_c", out_data, 32'hCCCC0000);
        @(negedge clk);
        chk("bp_empty", {31'd0, out_valid}, 32'd0);
`else
        in_valid = 1'b1; in_mode = 2'b00; in_imm = 16'hAAAA;   // A
        @(negedge clk);
        in_mode = 2'b01; in_imm = 16'hBBBB;                      // B waits
        chk("bp_rdy_full", {31'd0, in_ready}, 32'd0);
        repeat (2) @(negedge clk);
        chk("bp_hold_a", out_data, 32'hFFFFAAAA);
        out_ready = 1'b1;
        #1 chk("bp_rdy_comb", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_b", out_data, 32'h0000BBBB);
        @(negedge clk);
        chk("bp_empty", {31'd0, out_valid}, 32'd0);
`endif

        // continuous random stream, out_ready=1
        sent = 0; got = 0; cyc = 0;
        while (got < 100 && cyc < 150) begin
            if (out_valid) begin
                got++;
                if (q.size() == 0) chk("stream_extra", 32'd1, 32'd0);
                else chk("stream_data", out_data, q.pop_front());
            end
            if (sent < 100) begin
                r_imm = 16'($urandom); r_mode = 2'($urandom_range(0, 3));
                in_valid = 1'b1; in_imm = r_imm; in_mode = r_mode;
                #1;
                if (in_ready) begin
                    q.push_back(model(r_imm, r_mode));
                    sent++;
                end
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk("stream_count", got, 32'd100);
        chk("stream_cycles", cyc, 32'd101);

        // asynchronous reset with buffered items
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 2'b00; in_imm = 16'h1111;
        @(negedge clk);
        in_imm = 16'h2222;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("arst_out_data", out_data, 32'd0);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_rel_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_rel_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (3) @(negedge clk);
        chk("arst_no_stale", {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
